// File: rtl/dummy_accelerator_result_buffer_if.sv
// Upstream (pipeline) and downstream (core X-interface) result channels of the
// dummy accelerator result buffer; "slave" is the buffer side, "master" the environment.
interface dummy_accelerator_result_buffer_if #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned TAG_WIDTH = 9,
  parameter int unsigned DEPTH     = 4
);
  logic                     valid_i;
  logic                     ready_o;
  logic [WIDTH-1:0]         result_i;
  logic [TAG_WIDTH-1:0]     tag_i;
  logic                     valid_o;
  logic                     ready_i;
  logic [WIDTH-1:0]         result_o;
  logic [4:0]               rd_o;
  logic [TAG_WIDTH-6:0]     id_o;
  logic                     we_o;
  logic [$clog2(DEPTH):0]   count_o;

  modport slave (
    input  valid_i, result_i, tag_i, ready_i,
    output ready_o, valid_o, result_o, rd_o, id_o, we_o, count_o
  );

  modport master (
    output valid_i, result_i, tag_i, ready_i,
    input  ready_o, valid_o, result_o, rd_o, id_o, we_o, count_o
  );
endinterface

// File: rtl/dummy_accelerator_result_buffer.sv
// In-order result FIFO between the dummy accelerator pipeline and the core result channel.
// Optional zero-latency forwarding when empty: define DUMMY_ACC_RESULT_BUF_BYPASS_EN.
module dummy_accelerator_result_buffer_chk #(
  parameter int unsigned CW    = 3,
  parameter int unsigned DEPTH = 4
) (
  input logic          clk_i,
  input logic          rst_ni,
  input logic          push_s,
  input logic          pop_s,
  input logic [CW-1:0] count_q
);
  a_no_overflow : assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(push_s && (count_q == CW'(DEPTH))));
  a_no_underflow : assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(pop_s && (count_q == '0)));
endmodule

module dummy_accelerator_result_buffer #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned TAG_WIDTH = 9,
  parameter int unsigned DEPTH     = 4
) (
  input logic clk_i,
  input logic rst_ni,
  input logic flush_i,
  dummy_accelerator_result_buffer_if.slave bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  typedef struct packed {
    logic [WIDTH-1:0]     result;
    logic [TAG_WIDTH-1:0] tag;
  } entry_t;

  entry_t        mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push_s, pop_s, fifo_valid_s, ready_s, fwd_s, bypass_s, valid_s;
  entry_t        head_s, out_s;

  always_comb begin
    fifo_valid_s = (count_q != '0);
    ready_s      = (count_q != FULL_CNT);
`ifdef DUMMY_ACC_RESULT_BUF_BYPASS_EN
    // Empty buffer shows the incoming entry; it is consumed directly only if the core is ready.
    fwd_s        = (count_q == '0) && bus.valid_i;
    bypass_s     = fwd_s && bus.ready_i;
`else
    fwd_s        = 1'b0;
    bypass_s     = 1'b0;
`endif
    push_s       = bus.valid_i && ready_s && !bypass_s;
    pop_s        = fifo_valid_s && bus.ready_i;
    valid_s      = fifo_valid_s || fwd_s;
    head_s       = mem_q[rptr_q];
    if (fwd_s) begin
      out_s = '{result: bus.result_i, tag: bus.tag_i};
    end else begin
      out_s = head_s;
    end
  end

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (flush_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (push_s) begin
        wptr_d = wptr_q + PTR_ONE;
      end else begin
        wptr_d = wptr_q;
      end
      if (pop_s) begin
        rptr_d = rptr_q + PTR_ONE;
      end else begin
        rptr_d = rptr_q;
      end
      case ({push_s, pop_s})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage is deliberately left unreset; only occupancy state defines validity.
  always_ff @(posedge clk_i) begin
    if (push_s && !flush_i) begin
      mem_q[wptr_q] <= '{result: bus.result_i, tag: bus.tag_i};
    end
  end

  always_comb begin
    bus.ready_o  = ready_s;
    bus.valid_o  = valid_s;
    bus.result_o = out_s.result;
    bus.rd_o     = out_s.tag[4:0];
    bus.id_o     = out_s.tag[TAG_WIDTH-1:5];
    bus.we_o     = valid_s && (out_s.tag[4:0] != 5'd0);
    bus.count_o  = count_q;
  end

  dummy_accelerator_result_buffer_chk #(.CW(CW), .DEPTH(DEPTH)) u_chk (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_s  (push_s),
    .pop_s   (pop_s),
    .count_q (count_q)
  );
endmodule

// File: tb/tb_dummy_accelerator_result_buffer.sv
// Directed, table-driven bench for dummy_accelerator_result_buffer (DEPTH = 4).
module tb_dummy_accelerator_result_buffer;
  logic clk = 1'b0;
  logic rst_n;
  logic flush;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  dummy_accelerator_result_buffer_if #(.WIDTH(32), .TAG_WIDTH(9), .DEPTH(4)) bus ();

  dummy_accelerator_result_buffer #(.WIDTH(32), .TAG_WIDTH(9), .DEPTH(4)) dut (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .flush_i (flush),
    .bus     (bus.slave)
  );

  typedef struct {
    logic        fl;
    logic        vi;
    logic [31:0] res;
    logic [4:0]  rd;
    logic [3:0]  id;
    logic        rdy;
    logic        ev;
    logic [2:0]  ecnt;
    logic        erdy;
    logic [31:0] eres;
    logic [4:0]  erd;
    logic [3:0]  eid;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mkv(input int fl, input int vi, input logic [31:0] res, input int rd,
                               input int id, input int rdy, input int ev, input int ecnt,
                               input int erdy, input logic [31:0] eres, input int erd, input int eid);
    vec_t v;
    v.fl = 1'(fl); v.vi = 1'(vi); v.res = res; v.rd = 5'(rd); v.id = 4'(id); v.rdy = 1'(rdy);
    v.ev = 1'(ev); v.ecnt = 3'(ecnt); v.erdy = 1'(erdy); v.eres = eres; v.erd = 5'(erd); v.eid = 4'(eid);
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic fl, input logic vi, input logic [31:0] res, input logic [4:0] rd,
                       input logic [3:0] id, input logic rdy);
    flush        = fl;
    bus.valid_i  = vi;
    bus.result_i = res;
    bus.tag_i    = {id, rd};
    bus.ready_i  = rdy;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 5'd0, 4'd0, 1'b1);
    #12;
    chk("rst_valid", {31'd0, bus.valid_o}, 32'd0);
    chk("rst_we",    {31'd0, bus.we_o},    32'd0);
    chk("rst_ready", {31'd0, bus.ready_o}, 32'd1);
    chk("rst_count", {29'd0, bus.count_o}, 32'd0);
    rst_n = 1'b1;

`ifndef DUMMY_ACC_RESULT_BUF_BYPASS_EN
    // Expected fields describe outputs in the cycle the inputs are applied (before the edge).
    vecs.push_back(mkv(0,1,32'hDEADBEEF,7,3,1, 0,0,1, 0,0,0));
    vecs.push_back(mkv(0,0,0,0,0,1, 1,1,1, 32'hDEADBEEF,7,3));
    vecs.push_back(mkv(0,1,32'h11,0,1,1, 0,0,1, 0,0,0));
    vecs.push_back(mkv(0,0,0,0,0,1, 1,1,1, 32'h11,0,1));
    vecs.push_back(mkv(0,0,0,0,0,1, 0,0,1, 0,0,0));
    vecs.push_back(mkv(0,1,1,1,1,0, 0,0,1, 0,0,0));
    vecs.push_back(mkv(0,1,2,2,2,0, 1,1,1, 1,1,1));
    vecs.push_back(mkv(0,1,3,3,3,0, 1,2,1, 1,1,1));
    vecs.push_back(mkv(0,1,4,4,4,0, 1,3,1, 1,1,1));
    vecs.push_back(mkv(0,1,5,5,5,0, 1,4,0, 1,1,1));
    vecs.push_back(mkv(0,1,5,5,5,0, 1,4,0, 1,1,1));
    vecs.push_back(mkv(0,1,5,5,5,1, 1,4,0, 1,1,1));
    vecs.push_back(mkv(0,1,5,5,5,1, 1,3,1, 2,2,2));
    vecs.push_back(mkv(0,0,0,0,0,1, 1,3,1, 3,3,3));
    vecs.push_back(mkv(0,0,0,0,0,1, 1,2,1, 4,4,4));
    vecs.push_back(mkv(0,0,0,0,0,1, 1,1,1, 5,5,5));
    vecs.push_back(mkv(0,0,0,0,0,1, 0,0,1, 0,0,0));
    vecs.push_back(mkv(0,1,32'h21,2,2,0, 0,0,1, 0,0,0));
    vecs.push_back(mkv(0,1,32'h22,0,3,0, 1,1,1, 32'h21,2,2));
    vecs.push_back(mkv(0,1,32'h23,4,4,0, 1,2,1, 32'h21,2,2));
    vecs.push_back(mkv(0,1,32'h24,5,5,0, 1,3,1, 32'h21,2,2));
    vecs.push_back(mkv(0,1,32'h25,6,6,1, 1,4,0, 32'h21,2,2));
    vecs.push_back(mkv(0,1,32'h25,6,6,0, 1,3,1, 32'h22,0,3));
    vecs.push_back(mkv(0,0,0,0,0,0, 1,4,0, 32'h22,0,3));
    vecs.push_back(mkv(0,0,0,0,0,1, 1,4,0, 32'h22,0,3));
    vecs.push_back(mkv(0,0,0,0,0,1, 1,3,1, 32'h23,4,4));
    vecs.push_back(mkv(0,0,0,0,0,1, 1,2,1, 32'h24,5,5));
    vecs.push_back(mkv(0,0,0,0,0,1, 1,1,1, 32'h25,6,6));
    vecs.push_back(mkv(0,0,0,0,0,1, 0,0,1, 0,0,0));
    vecs.push_back(mkv(0,1,32'h31,1,1,0, 0,0,1, 0,0,0));
    vecs.push_back(mkv(0,1,32'h32,2,2,0, 1,1,1, 32'h31,1,1));
    vecs.push_back(mkv(0,1,32'h33,3,3,0, 1,2,1, 32'h31,1,1));
    vecs.push_back(mkv(1,1,32'h34,4,4,0, 1,3,1, 32'h31,1,1));
    vecs.push_back(mkv(0,0,0,0,0,1, 0,0,1, 0,0,0));
    vecs.push_back(mkv(0,1,32'h35,5,5,1, 0,0,1, 0,0,0));
    vecs.push_back(mkv(0,0,0,0,0,1, 1,1,1, 32'h35,5,5));
    vecs.push_back(mkv(0,0,0,0,0,1, 0,0,1, 0,0,0));

    foreach (vecs[i]) begin
      @(posedge clk); #1;
      drive(vecs[i].fl, vecs[i].vi, vecs[i].res, vecs[i].rd, vecs[i].id, vecs[i].rdy);
      @(negedge clk);
      chk($sformatf("v%0d_valid", i), {31'd0, bus.valid_o}, {31'd0, vecs[i].ev});
      chk($sformatf("v%0d_count", i), {29'd0, bus.count_o}, {29'd0, vecs[i].ecnt});
      chk($sformatf("v%0d_ready", i), {31'd0, bus.ready_o}, {31'd0, vecs[i].erdy});
      chk($sformatf("v%0d_we", i), {31'd0, bus.we_o},
          {31'd0, vecs[i].ev && (vecs[i].erd != 5'd0)});
      if (vecs[i].ev) begin
        chk($sformatf("v%0d_result", i), bus.result_o, vecs[i].eres);
        chk($sformatf("v%0d_rd", i), {27'd0, bus.rd_o}, {27'd0, vecs[i].erd});
        chk($sformatf("v%0d_id", i), {28'd0, bus.id_o}, {28'd0, vecs[i].eid});
      end
    end
`else
    // Empty and core ready: same-cycle forwarding, nothing stored.
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 32'h55, 5'd7, 4'd3, 1'b1);
    @(negedge clk);
    chk("byp_valid",  {31'd0, bus.valid_o}, 32'd1);
    chk("byp_result", bus.result_o, 32'h55);
    chk("byp_rd",     {27'd0, bus.rd_o}, 32'd7);
    chk("byp_we",     {31'd0, bus.we_o}, 32'd1);
    chk("byp_count",  {29'd0, bus.count_o}, 32'd0);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 32'h0, 5'd0, 4'd0, 1'b1);
    @(negedge clk);
    chk("byp_after_valid", {31'd0, bus.valid_o}, 32'd0);
    chk("byp_after_count", {29'd0, bus.count_o}, 32'd0);
    // Empty but core stalled: entry is shown and also written into the FIFO.
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 32'h66, 5'd0, 4'd2, 1'b0);
    @(negedge clk);
    chk("stall_valid",  {31'd0, bus.valid_o}, 32'd1);
    chk("stall_result", bus.result_o, 32'h66);
    chk("stall_we",     {31'd0, bus.we_o}, 32'd0);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 32'h0, 5'd0, 4'd0, 1'b0);
    @(negedge clk);
    chk("stall_count",  {29'd0, bus.count_o}, 32'd1);
    chk("stall_head",   bus.result_o, 32'h66);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 32'h0, 5'd0, 4'd0, 1'b1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("stall_drained", {29'd0, bus.count_o}, 32'd0);
`endif

    // Asynchronous reset in the middle of a cycle with two entries buffered.
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 32'h41, 5'd1, 4'd1, 1'b0);
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 32'h42, 5'd2, 4'd2, 1'b0);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 32'h0, 5'd0, 4'd0, 1'b0);
    @(negedge clk);
    chk("pre_arst_count", {29'd0, bus.count_o}, 32'd2);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", {31'd0, bus.valid_o}, 32'd0);
    chk("arst_count", {29'd0, bus.count_o}, 32'd0);
    chk("arst_ready", {31'd0, bus.ready_o}, 32'd1);
    chk("arst_we",    {31'd0, bus.we_o},    32'd0);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("post_arst_count", {29'd0, bus.count_o}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/dummy_accelerator_result_buffer.md
Name: dummy_accelerator_result_buffer

Overview:
- Result-side stage directly downstream of the dummy accelerator pipeline.
- Captures each (result, tag) pair produced by the pipeline into a small in-order FIFO and presents it to the core's X-interface result channel with a valid/ready handshake.
- Decouples pipeline back-pressure from core result acceptance, so a slow core does not stall the pipeline until the buffer fills.
- Derives the register-file write-enable from the destination register field of the tag.

Parameters:
- WIDTH, 32, result data width.
- TAG_WIDTH, 9, tag width; tag[4:0] = rd, tag[TAG_WIDTH-1:5] = instruction id.
- DEPTH, 4, FIFO entries; power of two, >= 2.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- flush_i  in  1  synchronous flush; discards all entries.
- valid_i  in  1  upstream result valid.
- ready_o  out  1  buffer can accept an entry.
- result_i  in  WIDTH  upstream result.
- tag_i  in  TAG_WIDTH  upstream tag.
- valid_o  out  1  result valid to core.
- ready_i  in  1  core accepts result.
- result_o  out  WIDTH  head result.
- rd_o  out  5  head destination register (tag[4:0]).
- id_o  out  TAG_WIDTH-5  head instruction id.
- we_o  out  1  write-enable; 1 iff rd_o != 0 and valid_o.
- count_o  out  $clog2(DEPTH)+1  current occupancy.

Behaviour:
- Storage: DEPTH-entry circular buffer.
  - Write pointer and read pointer are $clog2(DEPTH) bits; both wrap naturally from DEPTH-1 to 0.
  - count register ranges 0..DEPTH.
- Push = valid_i && ready_o. Pop = valid_o && ready_i.
- ready_o = (count != DEPTH). It is registered-derived: no combinational path from ready_i to ready_o.
- valid_o = (count != 0). result_o, rd_o and id_o always show the head entry.
  - Head-entry outputs are don't-care when empty; the bench checks them only when valid_o = 1.
- Latency: an entry pushed in cycle N is visible on valid_o in cycle N+1. No fall-through unless the optional feature is enabled.
- Simultaneous push and pop:
  - Both pointers advance; count unchanged.
  - When full: push is refused (ready_o = 0) and pop proceeds; count becomes DEPTH-1.
  - When empty: only the push occurs (pop impossible); count becomes 1.
- Ordering: strictly FIFO. Tags are never reordered or merged.
- Holding rule: while valid_o = 1 and ready_i = 0, result_o, rd_o, id_o and we_o stay stable.
- Reset (rst_ni = 0, asynchronous, at any time, including mid-transfer):
  - Pointers and count cleared to 0.
  - Outputs: valid_o = 0, we_o = 0, ready_o = 1, count_o = 0.
  - Storage contents are not reset.
- flush_i = 1 in a cycle:
  - Next state equals the reset state.
  - Flush has priority over a coincident push or pop; the pushed entry is dropped.
  - ready_o in the flush cycle follows the pre-flush count.
- No state machine beyond pointers and count. Overflow and underflow cannot occur by construction.
  - Assertions (simulation only): push never occurs when count = DEPTH; pop never occurs when count = 0.

Optional Feature:
- Macro: DUMMY_ACC_RESULT_BUF_BYPASS_EN.
- Defined:
  - When count = 0, valid_i = 1 and ready_i = 1, the input is forwarded combinationally in the same cycle: valid_o = 1, result_o = result_i, rd_o/id_o from tag_i, we_o from tag_i.
  - Neither pointer moves and count stays 0 (zero-latency path).
  - If count = 0, valid_i = 1 and ready_i = 0, the entry is written into the FIFO normally.
  - valid_o = (count != 0) || valid_i when count = 0.
- Undefined: behaviour exactly as in Behaviour; the minimum latency is 1 cycle.

Test Plan:
- Reset with ready_i = 1, then push result=0xDEADBEEF, tag={id=3, rd=7} -> next cycle: valid_o = 1, result_o = 0xDEADBEEF, rd_o = 7, id_o = 3, we_o = 1; following cycle: valid_o = 0, count_o = 0.
- Push rd = 0 entry -> valid_o = 1, we_o = 0.
- ready_i = 0; push 5 entries (results 1..5) with DEPTH = 4 -> ready_o drops after the 4th push, count_o = 4, 5th held upstream. Raise ready_i -> outputs 1, 2, 3, 4, 5 in order, one per cycle; ready_o = 1 again after the first pop.
- Full buffer; assert push and pop together -> pop occurs, push refused, count_o = 3. Next cycle push accepted -> count_o = 4.
- 3 entries buffered; flush_i = 1 with simultaneous valid_i = 1 -> next cycle: count_o = 0, valid_o = 0, pushed entry absent from later output.
- rst_ni asserted asynchronously mid-cycle with count_o = 2 -> valid_o = 0 and count_o = 0 immediately, without a clock edge. With DUMMY_ACC_RESULT_BUF_BYPASS_EN: empty buffer, valid_i = 1, ready_i = 1, result = 0x55 -> valid_o = 1 and result_o = 0x55 in the same cycle, count_o remains 0.
